// File: rtl/game_pkg.sv
// Shared definitions for the game motion blocks.
//   jump_state_t     : jump FSM state encoding
//   jump_dbg_t       : registers kept only for debug probing
//   TICK_DIV_DEFAULT : clock cycles per one-pixel motion step
//   X_MAX_DEFAULT    : rightmost legal x coordinate
//   sat_inc()        : increment that saturates at a limit
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RISE,
    ST_FALL,
    ST_DONE
  } jump_state_t;

  typedef struct packed {
    logic [7:0] origin_x;
    logic [7:0] apex_x;
  } jump_dbg_t;

  localparam logic [25:0] TICK_DIV_DEFAULT = 26'd833333;
  localparam logic [7:0]  X_MAX_DEFAULT    = 8'd159;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Motion step timer: counts enabled cycles and pulses tick on the last
// cycle of every DIV-cycle period.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   clear : synchronous counter clear
//   en    : count enable
//   tick  : high during the cycle the counter holds DIV-1 (while en)
module tick_gen
  import game_pkg::*;
#(
  parameter logic [25:0] DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 26'd1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 26'd1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jump_motion.sv
// Jump animation controller: on start, rises diagonally from the current
// character position to the apex height, falls back to the ground level,
// then pulses done. x advances one pixel per step, saturating at X_MAX.
//   clk, reset       : clock / asynchronous active-high reset
//   start            : one-cycle jump request (ignored unless idle)
//   c_x, c_y         : current character position (c_y is ground level)
//   e_x, e_y         : apex from the endpoint calculator
//   ep_enable        : endpoint calculator enable (high in LOAD)
//   pos_x, pos_y     : animated position
//   busy             : jump in progress (LOAD, RISE, FALL)
//   done             : one-cycle pulse at jump end
module jump_motion
  import game_pkg::*;
#(
  parameter logic [25:0] TICK_DIV = TICK_DIV_DEFAULT,
  parameter logic [7:0]  X_MAX    = X_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] c_x,
  input  logic [6:0] c_y,
  input  logic [7:0] e_x,
  input  logic [6:0] e_y,
  output logic       ep_enable,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic       busy,
  output logic       done
);

  jump_state_t state, state_d;
  logic [7:0]  pos_x_d;
  logic [6:0]  pos_y_d;
  logic [6:0]  origin_y, origin_y_d;
  logic [6:0]  apex_y, apex_y_d;
  jump_dbg_t   dbg_unused, dbg_d;
  logic        cnt_clear;
  logic        tick;

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .en   ((state == ST_RISE) || (state == ST_FALL)),
    .tick (tick)
  );

  // Outputs are pure state decodes, so reset clears them immediately.
  assign ep_enable = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD) || (state == ST_RISE) || (state == ST_FALL);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_d    = state;
    pos_x_d    = pos_x;
    pos_y_d    = pos_y;
    origin_y_d = origin_y;
    apex_y_d   = apex_y;
    dbg_d      = dbg_unused;
    cnt_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pos_x_d        = c_x;
          pos_y_d        = c_y;
          origin_y_d     = c_y;
          dbg_d.origin_x = c_x;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_clear    = 1'b1;
        dbg_d.apex_x = e_x;
        // An apex below ground means origin - apex underflowed: clamp to top.
        apex_y_d     = (e_y > origin_y) ? '0 : e_y;
        state_d      = (apex_y_d == origin_y) ? ST_DONE : ST_RISE;
      end
      ST_RISE: begin
        if (tick) begin
          pos_x_d = sat_inc(pos_x, X_MAX);
          pos_y_d = pos_y - 7'd1;
          if (pos_y_d == apex_y) state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (tick) begin
          pos_x_d = sat_inc(pos_x, X_MAX);
          pos_y_d = pos_y + 7'd1;
          if (pos_y_d == origin_y) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      origin_y   <= '0;
      apex_y     <= '0;
      dbg_unused <= '0;
    end else begin
      state      <= state_d;
      pos_x      <= pos_x_d;
      pos_y      <= pos_y_d;
      origin_y   <= origin_y_d;
      apex_y     <= apex_y_d;
      dbg_unused <= dbg_d;
    end
  end

endmodule

// File: tb/tb_jump_motion.sv
// Bench for jump_motion with TICK_DIV=4: directed jumps with hand-computed
// expectations, then random traffic checked every cycle against a
// time-offset model of the trajectory.
module tb_jump_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] c_x, e_x;
  logic [6:0] c_y, e_y;
  logic       ep_enable, busy, done;
  logic [7:0] pos_x;
  logic [6:0] pos_y;

  always #5 clk = ~clk;

  jump_motion #(
    .TICK_DIV(26'd4),
    .X_MAX   (8'd159)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .c_x      (c_x),
    .c_y      (c_y),
    .e_x      (e_x),
    .e_y      (e_y),
    .ep_enable(ep_enable),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Model: a jump is described by its cycle offset k since the start edge.
  // k=1 is the load cycle; from k=2 one step happens every 4 cycles,
  // N steps up then N steps down; the done cycle is k = 2 + 8N.
  bit m_active;
  int m_k, m_ox, m_oy, m_ay, m_px, m_py;

  function automatic int m_steps();
    return (m_k < 2) ? 0 : (m_k - 2) / 4;
  endfunction

  function automatic int m_n();
    return m_oy - m_ay;
  endfunction

  function automatic int m_end();
    return 2 + 8 * m_n();
  endfunction

  function automatic int exp_x();
    int t;
    if (!m_active) return m_px;
    if (m_k == 1) return m_ox;
    t = m_steps();
    if (m_ox >= 159) return m_ox;
    return (m_ox + t > 159) ? 159 : m_ox + t;
  endfunction

  function automatic int exp_y();
    int t;
    if (!m_active) return m_py;
    if (m_k == 1) return m_oy;
    t = m_steps();
    return (t <= m_n()) ? m_oy - t : m_oy - (2 * m_n() - t);
  endfunction

  function automatic int exp_busy();
    if (!m_active) return 0;
    if (m_k == 1) return 1;
    return (m_k < m_end()) ? 1 : 0;
  endfunction

  function automatic int exp_done();
    return (m_active && m_k >= 2 && m_k == m_end()) ? 1 : 0;
  endfunction

  function automatic int exp_ep();
    return (m_active && m_k == 1) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_px     <= 0;
      m_py     <= 0;
    end else if (m_active) begin
      if (m_k == 1) begin
        m_ay <= (int'(e_y) > m_oy) ? 0 : int'(e_y);
        m_k  <= 2;
      end else if (m_k == m_end()) begin
        m_active <= 1'b0;
        m_px     <= exp_x();
        m_py     <= exp_y();
      end else begin
        m_k <= m_k + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_ox     <= int'(c_x);
      m_oy     <= int'(c_y);
      m_px     <= int'(c_x);
      m_py     <= int'(c_y);
    end
  end

  always @(negedge clk) begin
    chk("pos_x", int'(pos_x), exp_x());
    chk("pos_y", int'(pos_y), exp_y());
    chk("busy", int'(busy), exp_busy());
    chk("done", int'(done), exp_done());
    chk("ep_enable", int'(ep_enable), exp_ep());
  end

  // Runs one jump; lat counts cycles from the start edge to the done cycle.
  // A second start (with other coordinates) is pulsed at cycle poke_at.
  task automatic jump(input int cx, input int cy, input int ex, input int ey,
                      input int poke_at, output int lat, output int dones,
                      output int min_y, output int fx, output int fy);
    bit seen;
    @(posedge clk); #2;
    c_x = 8'(cx); c_y = 7'(cy); e_x = 8'(ex); e_y = 7'(ey); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0; dones = 0; min_y = 127; fx = -1; fy = -1; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
      if (lat == poke_at) begin
        c_x = 8'd77; c_y = 7'd3; e_y = 7'd1;
      end
      if (int'(pos_y) < min_y) min_y = int'(pos_y);
      if (done) begin
        seen = 1'b1; dones = 1; fx = int'(pos_x); fy = int'(pos_y);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  int lat, dones, min_y, fx, fy, dn;

  initial begin
    reset = 1'b1; start = 1'b0;
    c_x = '0; c_y = '0; e_x = '0; e_y = '0;
    @(negedge clk);
    chk("reset_pos_x", int'(pos_x), 0);
    chk("reset_pos_y", int'(pos_y), 0);
    chk("reset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    jump(10, 100, 30, 80, -1, lat, dones, min_y, fx, fy);
    chk("basic_latency", lat, 162);
    chk("basic_apex_y", min_y, 80);
    chk("basic_end_x", fx, 50);
    chk("basic_end_y", fy, 100);
    chk("basic_dones", dones, 1);

    jump(10, 100, 30, 100, -1, lat, dones, min_y, fx, fy);
    chk("zero_latency", lat, 2);
    chk("zero_end_x", fx, 10);
    chk("zero_end_y", fy, 100);

    jump(150, 100, 190, 60, -1, lat, dones, min_y, fx, fy);
    chk("sat_latency", lat, 322);
    chk("sat_apex_y", min_y, 60);
    chk("sat_end_x", fx, 159);
    chk("sat_end_y", fy, 100);

    jump(5, 20, 0, 108, -1, lat, dones, min_y, fx, fy);
    chk("clamp_latency", lat, 162);
    chk("clamp_apex_y", min_y, 0);
    chk("clamp_end_x", fx, 45);
    chk("clamp_end_y", fy, 20);

    jump(10, 100, 30, 80, 30, lat, dones, min_y, fx, fy);
    chk("restart_latency", lat, 162);
    chk("restart_end_x", fx, 50);
    chk("restart_dones", dones, 1);

    // Abort during the fall phase (fall spans cycles 82..161).
    @(posedge clk); #2;
    c_x = 8'd10; c_y = 7'd100; e_x = 8'd30; e_y = 7'd80; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_pos_x", int'(pos_x), 0);
    chk("abort_pos_y", int'(pos_y), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    dn = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);

    jump(0, 50, 0, 45, -1, lat, dones, min_y, fx, fy);
    chk("after_abort_latency", lat, 42);
    chk("after_abort_end_x", fx, 10);
    chk("after_abort_end_y", fy, 50);

    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 39) == 0);
      c_x   = 8'($urandom);
      c_y   = 7'($urandom);
      e_x   = 8'($urandom);
      e_y   = 7'($urandom);
      reset = ($urandom_range(0, 1499) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
